// File: rtl/regfile_sched_pkg.sv
// Shared widths and the registered control bundle that drives register_block.
package regfile_sched_pkg;
    localparam int DEF_WARPS  = 8;
    localparam int DEF_LANES  = 8;
    localparam int DEF_REGS   = 64;
    localparam int DEF_DATA_W = 64;
    localparam int WW = $clog2(DEF_WARPS);
    localparam int AW = $clog2(DEF_REGS);

    typedef struct packed {
        logic [WW-1:0]                  warp;
        logic                           rd_vld;
        logic [DEF_LANES-1:0]           read_en_0;
        logic [DEF_LANES-1:0]           read_en_1;
        logic [DEF_LANES-1:0]           write_en;
        logic [AW-1:0]                  raddr_0;
        logic [AW-1:0]                  raddr_1;
        logic [AW-1:0]                  waddr;
        logic [DEF_LANES*DEF_DATA_W-1:0] wdata;
    } rb_ctrl_t;
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr) + i) % N);
            if (!any && req[k]) begin
                any    = 1'b1;
                idx    = k;
                gnt[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_access_scheduler.sv
// Arbitrates warp operand reads and one writeback onto register_block, with
// registered issue controls, a write-to-read bypass and a starvation guard.
module regfile_access_scheduler
    import regfile_sched_pkg::*;
#(
    parameter int NUM_WARPS    = DEF_WARPS,
    parameter int NUM_LANES    = DEF_LANES,
    parameter int NUM_REGS     = DEF_REGS,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_WARPS-1:0]          req_valid,
    output logic [NUM_WARPS-1:0]          req_ready,
    input  logic [NUM_WARPS*AW-1:0]       req_raddr_0,
    input  logic [NUM_WARPS*AW-1:0]       req_raddr_1,
    input  logic [NUM_WARPS-1:0]          req_use_1,
    input  logic [NUM_WARPS*NUM_LANES-1:0] req_lane_mask,
    input  logic                          wb_valid,
    output logic                          wb_ready,
    input  logic [WW-1:0]                 wb_warp,
    input  logic [AW-1:0]                 wb_addr,
    input  logic [NUM_LANES-1:0]          wb_mask,
    input  logic [NUM_LANES*DATA_W-1:0]   wb_data,
    output logic [WW-1:0]                 rb_warp_selector,
    output logic [NUM_LANES-1:0]          rb_read_en_0,
    output logic [NUM_LANES-1:0]          rb_read_en_1,
    output logic [NUM_LANES-1:0]          rb_write_en,
    output logic [AW-1:0]                 rb_raddr_0,
    output logic [AW-1:0]                 rb_raddr_1,
    output logic [AW-1:0]                 rb_waddr,
    output logic [NUM_LANES*DATA_W-1:0]   rb_wdata,
    input  logic [NUM_LANES*DATA_W-1:0]   rb_rdata_0,
    input  logic [NUM_LANES*DATA_W-1:0]   rb_rdata_1,
    output logic                          rsp_valid,
    output logic [WW-1:0]                 rsp_warp,
    output logic [NUM_LANES-1:0]          rsp_lane_mask,
    output logic [NUM_LANES*DATA_W-1:0]   rsp_rdata_0,
    output logic [NUM_LANES*DATA_W-1:0]   rsp_rdata_1
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [WW-1:0]               rr_ptr_q, rr_ptr_d, cand;
    logic [NUM_WARPS-1:0]        cand_oh;
    logic                        cand_vld, starve, rd_gnt, wb_acc, byp_0, byp_1;
    logic [SW-1:0]               starve_cnt_q, starve_cnt_d;
    rb_ctrl_t                    ctrl_q, ctrl_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [WW-1:0]               rsp_warp_q, rsp_warp_d;
    logic [NUM_LANES-1:0]        rsp_mask_q, rsp_mask_d;
    logic [NUM_LANES*DATA_W-1:0] rsp_d0_q, rsp_d0_d, rsp_d1_q, rsp_d1_d;

    rr_arbiter #(.N(NUM_WARPS)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (cand_oh),
        .idx (cand),
        .any (cand_vld)
    );

    // Starve mode only bites while a reader is actually waiting, so writes never lock up.
    always_comb begin
        starve    = cand_vld && (starve_cnt_q == SW'(STARVE_LIMIT));
        wb_ready  = !starve || (wb_warp == cand);
        wb_acc    = wb_valid && wb_ready;
        rd_gnt    = cand_vld && (starve || !wb_valid || (wb_warp == cand));
        req_ready = rd_gnt ? cand_oh : '0;
    end

    always_comb begin
        ctrl_d = '0;
        if (wb_acc) begin
            ctrl_d.warp     = wb_warp;
            ctrl_d.write_en = wb_mask;
            ctrl_d.waddr    = wb_addr;
            ctrl_d.wdata    = wb_data;
        end
        if (rd_gnt) begin
            ctrl_d.warp      = cand;
            ctrl_d.rd_vld    = 1'b1;
            ctrl_d.read_en_0 = req_lane_mask[cand*NUM_LANES +: NUM_LANES];
            ctrl_d.read_en_1 = req_use_1[cand] ? ctrl_d.read_en_0 : '0;
            ctrl_d.raddr_0   = req_raddr_0[cand*AW +: AW];
            ctrl_d.raddr_1   = req_raddr_1[cand*AW +: AW];
        end
        rr_ptr_d = rr_ptr_q;
        if (rd_gnt)
            rr_ptr_d = (cand == WW'(NUM_WARPS - 1)) ? '0 : cand + 1'b1;
        starve_cnt_d = starve_cnt_q;
        if (rd_gnt)
            starve_cnt_d = '0;
        else if (|req_valid && starve_cnt_q != SW'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // A co-issued write shares the warp, so an address match means the read sees stale data.
    always_comb begin
        byp_0       = (ctrl_q.waddr == ctrl_q.raddr_0);
        byp_1       = (ctrl_q.waddr == ctrl_q.raddr_1);
        rsp_valid_d = ctrl_q.rd_vld;
        rsp_warp_d  = ctrl_q.rd_vld ? ctrl_q.warp : '0;
        rsp_mask_d  = ctrl_q.read_en_0;
        rsp_d0_d    = '0;
        rsp_d1_d    = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (ctrl_q.read_en_0[l])
                rsp_d0_d[l*DATA_W +: DATA_W] = (byp_0 && ctrl_q.write_en[l]) ?
                    ctrl_q.wdata[l*DATA_W +: DATA_W] : rb_rdata_0[l*DATA_W +: DATA_W];
            if (ctrl_q.read_en_1[l])
                rsp_d1_d[l*DATA_W +: DATA_W] = (byp_1 && ctrl_q.write_en[l]) ?
                    ctrl_q.wdata[l*DATA_W +: DATA_W] : rb_rdata_1[l*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
            ctrl_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_warp_q   <= '0;
            rsp_mask_q   <= '0;
            rsp_d0_q     <= '0;
            rsp_d1_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            ctrl_q       <= ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_warp_q   <= rsp_warp_d;
            rsp_mask_q   <= rsp_mask_d;
            rsp_d0_q     <= rsp_d0_d;
            rsp_d1_q     <= rsp_d1_d;
        end
    end

    assign rb_warp_selector = ctrl_q.warp;
    assign rb_read_en_0     = ctrl_q.read_en_0;
    assign rb_read_en_1     = ctrl_q.read_en_1;
    assign rb_write_en      = ctrl_q.write_en;
    assign rb_raddr_0       = ctrl_q.raddr_0;
    assign rb_raddr_1       = ctrl_q.raddr_1;
    assign rb_waddr         = ctrl_q.waddr;
    assign rb_wdata         = ctrl_q.wdata;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_warp         = rsp_warp_q;
    assign rsp_lane_mask    = rsp_mask_q;
    assign rsp_rdata_0      = rsp_d0_q;
    assign rsp_rdata_1      = rsp_d1_q;
endmodule

// File: doc/regfile_access_scheduler.md
# regfile_access_scheduler

Shares the per-warp `register_block` between eight warp operand-fetch requesters and one writeback requester. Each cycle it picks a warp, drives `warp_selector`, both read ports and the write port from registered controls, then captures the lane data into a response register. It includes a same-cycle write-to-read bypass and a starvation guard. It sits between the warp scheduler/operand collector and `register_block`.

## Interface
- `NUM_WARPS`, 8: warps; warp id width `WW = $clog2(NUM_WARPS)`.
- `NUM_LANES`, 8: lanes per warp.
- `NUM_REGS`, 64: registers per lane; address width `AW = $clog2(NUM_REGS)`.
- `DATA_W`, 64: register width.
- `STARVE_LIMIT`, 4: consecutive read-blocked cycles before reads take priority.

- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_WARPS`: per-warp read request.
- `req_ready` out `NUM_WARPS`: one-hot grant, combinational.
- `req_raddr_0`, `req_raddr_1` in `NUM_WARPS*AW`: per-warp source addresses; warp w uses slice w.
- `req_use_1` in `NUM_WARPS`: port 1 needed.
- `req_lane_mask` in `NUM_WARPS*NUM_LANES`: active lanes.
- `wb_valid` in 1 / `wb_ready` out 1: writeback handshake.
- `wb_warp` in `WW`; `wb_addr` in `AW`; `wb_mask` in `NUM_LANES`; `wb_data` in `NUM_LANES*DATA_W`: writeback payload, lane l at slice l.
- `rb_warp_selector` out `WW`; `rb_read_en_0`, `rb_read_en_1`, `rb_write_en` out `NUM_LANES`; `rb_raddr_0`, `rb_raddr_1`, `rb_waddr` out `AW`; `rb_wdata` out `NUM_LANES*DATA_W`: to `register_block`, all registered.
- `rb_rdata_0`, `rb_rdata_1` in `NUM_LANES*DATA_W`: from `register_block`; combinational in the issue cycle.
- `rsp_valid` out 1; `rsp_warp` out `WW`; `rsp_lane_mask` out `NUM_LANES`; `rsp_rdata_0`, `rsp_rdata_1` out `NUM_LANES*DATA_W`: one-cycle response pulse with no backpressure.

## Operation
- **Arbitration (combinational, cycle A):**
  - Read candidate: the first warp with `req_valid` set, searching round-robin from `rr_ptr`.
  - Normal mode, `wb_valid`=1: `wb_ready`=1. The read candidate is also granted only if its warp equals `wb_warp` (co-issue).
  - Normal mode, `wb_valid`=0: the read candidate is granted.
  - Starve mode (`starve_cnt == STARVE_LIMIT`): the read candidate is granted. `wb_ready`=1 only if `wb_warp` equals the candidate warp.
- **Issue (edge ending A, outputs valid during cycle I):**
  - `rb_warp_selector` is loaded from the granted warp (read or write).
  - Read controls:
    - `rb_read_en_0` = lane mask.
    - `rb_read_en_1` = lane mask if `req_use_1`, else 0.
    - Addresses are loaded from the granted warp's slices.
  - Write controls: `rb_write_en` = `wb_mask`, plus `rb_waddr` and `rb_wdata`.
  - Any field with no grant is driven to 0.
  - `rr_ptr` <= granted read warp + 1, mod `NUM_WARPS`. It is unchanged if no read was granted.
- **Capture (edge ending I):**
  - `rsp_*` are loaded from `rb_rdata_*`. `rsp_valid` is high for exactly one cycle.
  - Lanes with `rb_read_en_x` low return 0.
- **Bypass:** applies when a co-issued write has `rb_waddr == rb_raddr_x`. For lanes with `rb_write_en` set, the captured port-x data is `rb_wdata` (the new value), not the stale `rb_rdata_x`.
- **Starvation counter:**
  - Increments (saturating at `STARVE_LIMIT`) in each cycle where any `req_valid` is set and no read is granted.
  - Clears on any read grant.
- **Reset:**
  - Clears all `rb_*` outputs, `rsp_*`, `rr_ptr` and `starve_cnt` to 0.
  - Reset mid-operation drops in-flight issue and capture silently; no response is produced.

## Timing
- Read latency: grant in cycle A -> `rsp_valid` in cycle A+2.
- Write: accepted in cycle A, committed at the edge ending cycle A+1. A read granted in cycle A+1 or later sees the new value. A co-issued read in cycle A sees it via bypass.
- Throughput: one warp per cycle, covering up to 2 reads per lane plus 1 write per lane.
- `req_ready` and `wb_ready` are combinational from valids, `rr_ptr` and `starve_cnt`. Requesters must hold their payload stable while valid is high and ready is low.
- Simultaneous valid on all warps: grants rotate w0, w1, …, w7, w0.
- Wrap-around: `rr_ptr` wraps from `NUM_WARPS-1` to 0.

## Structure
- Package `regfile_sched_pkg`: derived widths `WW` and `AW`, plus a `rb_ctrl_t` struct covering selector, enables, addresses and wdata.
- Sub-module `rr_arbiter` (parameterised N-way round-robin, with request, pointer, one-hot grant and index). The top module holds the issue register, capture/bypass logic and starvation counter.

## Test plan
- **Single read:** warp 3 requests addrs 5/9, mask 0xFF, `use_1`=1, with `register_block` preloaded. Required: `rsp_valid` 2 cycles later, `rsp_warp`=3, both ports return the preloaded data.
- **Round-robin:** all 8 warps request continuously. Required: grants in order 0..7 then back to 0, with one `rsp_valid` per cycle.
- **Co-issue with bypass:**
  - Stimulus: `wb` warp 2, addr 7, mask 0x0F, data 0xA5.. in the same cycle as a read by warp 2 of addr 7 on port 0.
  - Required: response lanes 0–3 = 0xA5.. and lanes 4–7 = old data.
- **Starvation:**
  - Stimulus: continuous `wb` to warp 0 while warp 5 requests.
  - Required: warp 5 is blocked for 4 cycles and granted in cycle 5 with `wb_ready`=0 in that cycle. The counter then clears.
- **Reset mid-flight:** assert `rst_n`=0 during cycle I of a granted read. Required: no `rsp_valid`, all `rb_*` = 0, and the first grant after reset goes to warp 0.
- **Partial mask:** warp 1, mask 0x81, `use_1`=0. Required: `rb_read_en_1`=0, and the response returns 0 in lanes 1–6 and in all port-1 lanes.
